// File: rtl/control_unit_if.sv
// Bundle of the control sequencer's instruction input, stop request and datapath strobes.
// The sequencer uses the master side; the datapath/select-and-encode side uses slave.
interface control_unit_if #(
  parameter int OPW = 5
);
  logic [31:0]    IR;
  logic           Stop;
  logic           PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin;
  logic           MDRread, MDRin, MDRout, IRin, Yin, HIin, Loin;
  logic           Gra, Grb, Grc, Rin, Rout;
  logic [OPW-1:0] ALU_opcode;
  logic           Run;

  modport master (
    input  IR, Stop,
    output PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           MDRread, MDRin, MDRout, IRin, Yin, HIin, Loin,
           Gra, Grb, Grc, Rin, Rout, ALU_opcode, Run
  );

  modport slave (
    output IR, Stop,
    input  PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           MDRread, MDRin, MDRout, IRin, Yin, HIin, Loin,
           Gra, Grb, Grc, Rin, Rout, ALU_opcode, Run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer for the single-bus datapath: one state per clock,
// strobes decoded from the registered state and the current IR opcode.
module control_unit #(
  parameter int OPW = 5,
  parameter int RFW = 4
) (
  input  logic          clk,
  input  logic          clr,
  control_unit_if.master bus
);
  localparam int OP_LSB = 32 - OPW;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

  state_t         state_reg;
  state_t         eoi_state;
  logic [OPW-1:0] opcode;
  logic           is_binary, is_muldiv, is_unary, is_halt, is_alu;
  logic           unused_fields;

  assign opcode = bus.IR[31:OP_LSB];
  // Register fields are decoded by the select-and-encode block, not here.
  assign unused_fields = ^{bus.IR[OP_LSB-1:OP_LSB-3*RFW], bus.IR[OP_LSB-3*RFW-1:0]};

  always_comb begin
    is_binary = (opcode >= OP_ADD) && (opcode <= OP_ROL);
    is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
    is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
    is_halt   = (opcode == OP_HALT);
    is_alu    = is_binary || is_muldiv || is_unary;
  end

  assign eoi_state = bus.Stop ? HALT : T0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= RST;
    end else begin
      case (state_reg)
        RST:  state_reg <= T0;
        T0:   state_reg <= T1;
        T1:   state_reg <= T2;
        T2:   state_reg <= T3;
        T3:   state_reg <= is_alu ? T4 : (is_halt ? HALT : eoi_state);
        T4:   state_reg <= T5;
        T5:   state_reg <= is_muldiv ? T6 : eoi_state;
        T6:   state_reg <= eoi_state;
        HALT: state_reg <= HALT;
        default: state_reg <= RST;
      endcase
    end
  end

  // Outputs cannot be registered at the T2->T3 edge: IR is loaded on that same edge.
  always_comb begin
    bus.PCout      = 1'b0;
    bus.MARin      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.Zin        = 1'b0;
    bus.ZLOout     = 1'b0;
    bus.ZHIout     = 1'b0;
    bus.PCin       = 1'b0;
    bus.MDRread    = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.HIin       = 1'b0;
    bus.Loin       = 1'b0;
    bus.Gra        = 1'b0;
    bus.Grb        = 1'b0;
    bus.Grc        = 1'b0;
    bus.Rin        = 1'b0;
    bus.Rout       = 1'b0;
    bus.ALU_opcode = '0;
    bus.Run        = (state_reg != RST) && (state_reg != HALT);
    case (state_reg)
      T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      T1: begin
        bus.ZLOout  = 1'b1;
        bus.PCin    = 1'b1;
        bus.MDRread = 1'b1;
        bus.MDRin   = 1'b1;
      end
      T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      T3: begin
        if (is_binary || is_muldiv) begin
          bus.Grb  = 1'b1;
          bus.Rout = 1'b1;
          bus.Yin  = 1'b1;
        end
      end
      T4: begin
        if (is_alu) begin
          bus.Grc        = !is_unary;
          bus.Grb        = is_unary;
          bus.Rout       = 1'b1;
          bus.Zin        = 1'b1;
          bus.ALU_opcode = opcode;
        end
      end
      T5: begin
        bus.ZLOout = 1'b1;
        if (is_muldiv) begin
          bus.Loin = 1'b1;
        end else begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end
      end
      T6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks instructions state by state and compares the
// full output vector against hand-built per-state expectations.
module tb_control_unit;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  control_unit_if #(.OPW(5)) bus ();

  control_unit #(.OPW(5), .RFW(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [24:0] obs;
  assign obs = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.ZLOout, bus.ZHIout, bus.PCin,
                bus.MDRread, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.HIin, bus.Loin,
                bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.Run, bus.ALU_opcode};

  localparam logic [24:0] S_PCOUT   = 25'd1 << 24;
  localparam logic [24:0] S_MARIN   = 25'd1 << 23;
  localparam logic [24:0] S_INCPC   = 25'd1 << 22;
  localparam logic [24:0] S_ZIN     = 25'd1 << 21;
  localparam logic [24:0] S_ZLOOUT  = 25'd1 << 20;
  localparam logic [24:0] S_ZHIOUT  = 25'd1 << 19;
  localparam logic [24:0] S_PCIN    = 25'd1 << 18;
  localparam logic [24:0] S_MDRREAD = 25'd1 << 17;
  localparam logic [24:0] S_MDRIN   = 25'd1 << 16;
  localparam logic [24:0] S_MDROUT  = 25'd1 << 15;
  localparam logic [24:0] S_IRIN    = 25'd1 << 14;
  localparam logic [24:0] S_YIN     = 25'd1 << 13;
  localparam logic [24:0] S_HIIN    = 25'd1 << 12;
  localparam logic [24:0] S_LOIN    = 25'd1 << 11;
  localparam logic [24:0] S_GRA     = 25'd1 << 10;
  localparam logic [24:0] S_GRB     = 25'd1 << 9;
  localparam logic [24:0] S_GRC     = 25'd1 << 8;
  localparam logic [24:0] S_RIN     = 25'd1 << 7;
  localparam logic [24:0] S_ROUT    = 25'd1 << 6;
  localparam logic [24:0] S_RUN     = 25'd1 << 5;

  localparam logic [24:0] E_IDLE = 25'd0;
  localparam logic [24:0] E_T0   = S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_RUN;
  localparam logic [24:0] E_T1   = S_ZLOOUT | S_PCIN | S_MDRREAD | S_MDRIN | S_RUN;
  localparam logic [24:0] E_T2   = S_MDROUT | S_IRIN | S_RUN;
  localparam logic [24:0] E_T3A  = S_GRB | S_ROUT | S_YIN | S_RUN;
  localparam logic [24:0] E_T3N  = S_RUN;
  localparam logic [24:0] E_T4B  = S_GRC | S_ROUT | S_ZIN | S_RUN;
  localparam logic [24:0] E_T4U  = S_GRB | S_ROUT | S_ZIN | S_RUN;
  localparam logic [24:0] E_T5R  = S_ZLOOUT | S_GRA | S_RIN | S_RUN;
  localparam logic [24:0] E_T5L  = S_ZLOOUT | S_LOIN | S_RUN;
  localparam logic [24:0] E_T6   = S_ZHIOUT | S_HIIN | S_RUN;

  localparam int K_BIN  = 0;
  localparam int K_UN   = 1;
  localparam int K_MD   = 2;
  localparam int K_SKIP = 3;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [24:0] exp);
    @(posedge clk);
    #1;
    check(tag, {7'd0, obs}, {7'd0, exp});
  endtask

  // stop_mode: 0 none, 1 pulse Stop during T1 only, 2 raise Stop from T2 onward.
  task automatic run_instr(input string tag, input logic [31:0] ir, input int kind,
                           input int stop_mode);
    logic [24:0] op;
    op = {20'd0, ir[31:27]};
    cyc({tag, ".T0"}, E_T0);
    bus.IR = ir;
    cyc({tag, ".T1"}, E_T1);
    if (stop_mode == 1) bus.Stop = 1'b1;
    cyc({tag, ".T2"}, E_T2);
    if (stop_mode == 1) bus.Stop = 1'b0;
    if (stop_mode == 2) bus.Stop = 1'b1;
    case (kind)
      K_BIN: begin
        cyc({tag, ".T3"}, E_T3A);
        cyc({tag, ".T4"}, E_T4B | op);
        cyc({tag, ".T5"}, E_T5R);
      end
      K_UN: begin
        cyc({tag, ".T3"}, E_T3N);
        cyc({tag, ".T4"}, E_T4U | op);
        cyc({tag, ".T5"}, E_T5R);
      end
      K_MD: begin
        cyc({tag, ".T3"}, E_T3A);
        cyc({tag, ".T4"}, E_T4B | op);
        cyc({tag, ".T5"}, E_T5L);
        cyc({tag, ".T6"}, E_T6);
      end
      default: cyc({tag, ".T3"}, E_T3N);
    endcase
    $display("instr %s ir=%h stop_mode=%0d errors_so_far=%0d", tag, ir, stop_mode, n_errors);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    clr = 1'b1;
    #1;
    check("clr_pulse", {7'd0, obs}, 32'd0);
    bus.Stop = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    bus.IR   = 32'd0;
    bus.Stop = 1'b0;
    #1;
    check("reset_async", {7'd0, obs}, 32'd0);
    cyc("reset_hold", E_IDLE);
    @(negedge clk);
    clr = 1'b0;

    run_instr("add", 32'h18918000, K_BIN, 0);

    // add interrupted by clr in T4
    cyc("add_clr.T0", E_T0);
    bus.IR = 32'h18918000;
    cyc("add_clr.T1", E_T1);
    cyc("add_clr.T2", E_T2);
    cyc("add_clr.T3", E_T3A);
    cyc("add_clr.T4", E_T4B | 25'd3);
    #2;
    clr = 1'b1;
    #1;
    check("clr_mid_T4", {7'd0, obs}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    $display("instr add_clr ir=18918000 reset in T4 errors_so_far=%0d", n_errors);

    run_instr("not",  32'h92280000, K_UN,   0);
    run_instr("mul",  32'h78338000, K_MD,   0);
    run_instr("div",  32'h80000000, K_MD,   0);
    run_instr("neg",  32'h88000000, K_UN,   0);
    run_instr("shl",  32'h48000000, K_BIN,  0);
    run_instr("nop",  32'hD0000000, K_SKIP, 0);
    run_instr("unk",  32'hF8000000, K_SKIP, 0);
    run_instr("ror_stoppulse", 32'h50000000, K_BIN, 1);
    run_instr("add_stop", 32'h18918000, K_BIN, 2);
    for (int i = 0; i < 10; i++) cyc("stop_halt_hold", E_IDLE);
    reset_pulse();

    run_instr("mul_after_rst", 32'h78338000, K_MD, 0);
    run_instr("halt", 32'hD8000000, K_SKIP, 0);
    for (int i = 0; i < 12; i++) cyc("halt_hold", E_IDLE);
    reset_pulse();
    cyc("post_halt.T0", E_T0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
